// File: rtl/ft60x_pkg.sv
// Shared constants and elaboration helpers for the FT60x chip-side FIFO model.
package ft60x_pkg;

  localparam int ERR_OE_CONTENTION = 0;
  localparam int ERR_WR_RD_BOTH    = 1;
  localparam int ERR_TX_DROP       = 2;
  localparam int ERR_W             = 3;

  // One buffered word carries the byte enables alongside the data bytes.
  function automatic int word_w(input int bus_bytes);
    return bus_bytes * 32'sd9;
  endfunction

  function automatic int ptr_w(input int depth);
    int w;
    int p;
    w = 32'sd0;
    p = 32'sd1;
    while (p < depth) begin
      p = p * 32'sd2;
      w = w + 32'sd1;
    end
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/ft60x_model_buf.sv
// Show-ahead register-array FIFO with occupancy count; flush empties it in one edge.
module ft60x_model_buf
  import ft60x_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 1024,
  localparam int AW   = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push & ~flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft60x_fifo_model.sv
// FT600/FT601 chip-side responder for the 245 synchronous FIFO bus, single channel.
// Optional flag stall injection is enabled by defining FT60X_MODEL_STALL_EN.
module ft60x_fifo_model
  import ft60x_pkg::*;
#(
  parameter int FIFO_BUS_WIDTH = 2,
  parameter int BUF_DEPTH      = 1024,
  parameter int STALL_PERIOD   = 64,
  parameter int STALL_LEN      = 5
) (
  input  logic                        usb_clk,
  input  logic                        rst,
  input  logic                        usb_rstn,
  output logic                        usb_txe_n,
  output logic                        usb_rxf_n,
  input  logic                        usb_wr_n,
  input  logic                        usb_rd_n,
  input  logic                        usb_oe_n,
  input  logic [FIFO_BUS_WIDTH-1:0]   usb_be_i,
  output logic [FIFO_BUS_WIDTH-1:0]   usb_be_o,
  output logic                        usb_be_t,
  input  logic [FIFO_BUS_WIDTH*8-1:0] usb_data_i,
  output logic [FIFO_BUS_WIDTH*8-1:0] usb_data_o,
  output logic                        usb_data_t,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [FIFO_BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic [FIFO_BUS_WIDTH-1:0]   s_axis_tkeep,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [FIFO_BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic [FIFO_BUS_WIDTH-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic [ERR_W-1:0]            proto_err
);

  localparam int DW = FIFO_BUS_WIDTH * 8;
  localparam int WW = word_w(FIFO_BUS_WIDTH);
  localparam int AW = ptr_w(BUF_DEPTH);
  localparam logic [AW:0]   RX_FULL_CNT = (AW+1)'(BUF_DEPTH);
  localparam logic [AW+1:0] TX_LIMIT    = (AW+2)'(BUF_DEPTH);

  logic          flush;
  logic          stall;
  logic          rx_push;
  logic          rx_pop;
  logic          rx_empty;
  logic [WW-1:0] rx_head;
  logic [AW:0]   rx_count;
  logic [AW:0]   rx_left;
  logic          wr_acc;
  logic          tx_pop;
  logic          tx_empty;
  logic [WW:0]   tx_head;
  logic [AW:0]   tx_count;
  logic [AW+1:0] tx_next;
  logic          stage_valid;
  logic [WW-1:0] stage_word;

  assign flush         = rst | ~usb_rstn;
  assign s_axis_tready = (rx_count != RX_FULL_CNT) & ~flush;
  assign rx_push       = s_axis_tvalid & s_axis_tready;
  assign rx_pop        = ~usb_rd_n & ~usb_oe_n & ~usb_rxf_n;
  assign wr_acc        = ~usb_wr_n & ~usb_txe_n;
  assign tx_pop        = m_axis_tvalid & m_axis_tready;

  // A push only shows on rxf_n one edge later; a pop is reflected immediately.
  assign rx_left = rx_count - (AW+1)'(rx_pop);
  assign tx_next = (AW+2)'(tx_count) + (AW+2)'(stage_valid) + (AW+2)'(wr_acc) - (AW+2)'(tx_pop);

  ft60x_model_buf #(.WIDTH(WW), .DEPTH(BUF_DEPTH)) u_rx_buf (
    .clk       (usb_clk),
    .flush     (flush),
    .push      (rx_push),
    .push_data ({s_axis_tkeep, s_axis_tdata}),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .empty     (rx_empty)
  );

  ft60x_model_buf #(.WIDTH(WW + 1), .DEPTH(BUF_DEPTH)) u_tx_buf (
    .clk       (usb_clk),
    .flush     (flush),
    .push      (stage_valid),
    .push_data ({stage_word, ~wr_acc}),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .empty     (tx_empty)
  );

  assign usb_be_t      = rst | usb_oe_n;
  assign usb_data_t    = usb_be_t;
  assign usb_data_o    = rx_empty ? '0 : rx_head[DW-1:0];
  assign usb_be_o      = rx_empty ? '0 : rx_head[WW-1:DW];
  assign m_axis_tvalid = ~tx_empty;
  assign m_axis_tdata  = tx_head[DW:1];
  assign m_axis_tkeep  = tx_head[WW:DW+1];
  assign m_axis_tlast  = tx_head[0] & ~tx_empty;

`ifdef FT60X_MODEL_STALL_EN
  localparam int SW = ptr_w(STALL_PERIOD);
  logic [SW-1:0] stall_cnt;

  // Free-running stall phase counter
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  assign stall = (stall_cnt < SW'(STALL_LEN));
`else
  assign stall = 1'b0;
  // Stall parameters build no logic here; an out-of-range pair only names an empty scope.
  if (STALL_LEN >= STALL_PERIOD) begin : g_stall_cfg_out_of_range
  end
`endif

  // Status flags
  always_ff @(posedge usb_clk) begin
    if (flush) begin
      usb_rxf_n <= 1'b1;
      usb_txe_n <= 1'b1;
    end else begin
      usb_rxf_n <= (rx_left == '0) | stall;
      usb_txe_n <= (tx_next >= TX_LIMIT) | stall;
    end
  end

  // One-word write staging; tlast is decided when the staged word commits
  always_ff @(posedge usb_clk) begin
    if (flush) begin
      stage_valid <= 1'b0;
      stage_word  <= '0;
    end else begin
      stage_valid <= wr_acc;
      if (wr_acc) stage_word <= {usb_be_i, usb_data_i};
    end
  end

  // Sticky protocol error flags survive a chip flush
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      proto_err <= '0;
    end else begin
      proto_err[ERR_OE_CONTENTION] <= proto_err[ERR_OE_CONTENTION] | (~usb_wr_n & ~usb_oe_n);
      proto_err[ERR_WR_RD_BOTH]    <= proto_err[ERR_WR_RD_BOTH] | (~usb_wr_n & ~usb_rd_n);
      proto_err[ERR_TX_DROP]       <= proto_err[ERR_TX_DROP] | (~usb_wr_n & usb_txe_n);
    end
  end

endmodule
